mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit directly downstream of the register file; consumes the two register read buses (BusA, BusB) for MULT/MULTU/DIV/DIVU.
- Holds the architectural HI/LO registers and supports MTHI/MTLO writes from the write-back bus.
- Provides Busy and Done so the pipeline control can stall MFHI/MFLO and back-to-back mult/div.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each, iteration count equals WIDTH

Ports:
Clk  input  1  clock, all state updates on posedge
Reset  input  1  synchronous, active-high reset
Start  input  1  launch operation; sampled only when Busy=0
Op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
BusA  input  WIDTH  operand A (multiplicand / dividend) from register file
BusB  input  WIDTH  operand B (multiplier / divisor) from register file
HiWr  input  1  MTHI: write BusW into Hi
LoWr  input  1  MTLO: write BusW into Lo
BusW  input  WIDTH  write-back data for HiWr/LoWr
Hi  output  WIDTH  HI register: product[2W-1:W] or remainder
Lo  output  WIDTH  LO register: product[W-1:0] or quotient
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse when Hi/Lo updated with a result

Behaviour:
- Reset (synchronous, any state): Hi=0, Lo=0, Busy=0, Done=0, FSM to IDLE; an in-flight operation is abandoned with no Hi/Lo update.
- FSM states: IDLE, RUN, FIX.
- IDLE: Start=1 at edge T0 latches Op, BusA and BusB, converts signed operands to magnitudes and records the result sign(s). The iteration counter clears to 0 and the FSM moves to RUN. Busy=1 from the cycle after T0.
- RUN: performs one iteration per cycle, WIDTH cycles in total (edges T1..T32 for WIDTH=32).
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract over remainder/quotient.
  - The counter reaching WIDTH-1 moves the FSM to FIX.
- FIX (edge T33):
  - Applies sign correction: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - Writes Hi/Lo, sets Done=1 for exactly the following cycle, clears Busy, and returns to IDLE.
- Latency: Start edge to Hi/Lo valid is WIDTH+1 edges (33). Busy is high for 33 cycles. A new Start is accepted on the cycle Done is high.
- Start while Busy=1 is ignored; operands are not re-latched.
- HiWr/LoWr:
  - Honoured only when Busy=0, written at the edge. Both may be set in the same cycle.
  - Ignored while Busy=1.
  - If asserted together with Start in IDLE, the write occurs, and the later result overwrites it.
- Divide by zero (BusB=0): full latency still applies. Lo = all ones, Hi = dividend (unsigned and signed alike). No exception is raised.
- Signed overflow (DIV of 0x80000000 by 0xFFFFFFFF): Lo=0x80000000, Hi=0.
- Operand A and B may come from the same register; both are latched at T0, so later register-file writes do not affect the result.
- Hi/Lo hold their value in all other cycles. Done=0 except the single cycle after FIX.

Test Plan:
- Reset mid-RUN: Start MULTU 5×7, assert Reset at cycle 10 -> next cycle Busy=0, Hi=0, Lo=0, Done never pulses.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> after 33 cycles Hi=0xFFFFFFFE, Lo=0x00000001, Done high exactly one cycle, Busy high exactly 33 cycles.
- MULT -3 × 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. DIV -7 / 2 -> Lo=0xFFFFFFFD (−3), Hi=0xFFFFFFFF (−1).
- DIVU 100 / 0 -> Lo=0xFFFFFFFF, Hi=100. DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Start pulsed again at cycle 5 of a DIVU 100/7 with different operands, plus HiWr=1 with BusW=0xDEAD while busy -> both ignored; result Lo=14, Hi=2.
- Idle LoWr with BusW=0x1234, then HiWr with BusW=0xABCD -> Lo=0x1234, Hi=0xABCD, Done stays 0. Back-to-back: Start on the Done cycle -> accepted, second result 33 cycles later.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, then a sign-fix cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] BusA,
   input  logic [WIDTH-1:0] BusB,
   input  logic             HiWr,
   input  logic             LoWr,
   input  logic [WIDTH-1:0] BusW,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done
);

   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               is_div_q, is_div_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               div_zero_q, div_zero_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               signed_op;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, div_shift, div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   // The accumulator holds {partial product, multiplier} for multiply and
   // {remainder, dividend/quotient} for divide; opnd_q is the other operand.
   always_comb begin
      signed_op = ~Op[0];
      a_mag     = (signed_op && BusA[WIDTH-1]) ? -BusA : BusA;
      b_mag     = (signed_op && BusB[WIDTH-1]) ? -BusB : BusB;

      mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      div_shift = acc_q[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, opnd_q};

      prod_fix  = neg_q ? -acc_q : acc_q;
      quo_fix   = div_zero_q ? '1 : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem_fix   = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opnd_d     = opnd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      div_zero_d = div_zero_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            if (HiWr) hi_d = BusW;
            if (LoWr) lo_d = BusW;
            if (Start) begin
               is_div_d   = Op[1];
               neg_d      = signed_op && (BusA[WIDTH-1] ^ BusB[WIDTH-1]);
               rem_neg_d  = signed_op && BusA[WIDTH-1];
               div_zero_d = Op[1] && (BusB == '0);
               acc_d      = Op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
               opnd_d     = Op[1] ? b_mag : a_mag;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (is_div_q) begin
               if (!div_diff[WIDTH])
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
               else
                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
         end
         FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end else begin
               hi_d = prod_fix[2*WIDTH-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         opnd_q     <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         div_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opnd_q     <= opnd_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         div_zero_q <= div_zero_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign Hi   = hi_q;
   assign Lo   = lo_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule
